// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   r_state_t / w_state_t   : read and write FSM states
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACC,
    R_RESP
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACC,
    W_RESP
  } w_state_t;

endpackage

// File: rtl/axi_sram_slv_if.sv
// AXI4-Lite bus bundle between a master and the SRAM responder.
//   AR/R : read address and read data channels
//   AW/W/B : write address, write data and write response channels
//   slave modport is the responder view, master modport the initiator view.
interface axi_sram_slv_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/sram_1r1w.sv
// Word-addressed 32-bit SRAM, one synchronous read port and one byte-masked
// write port.
//   re_i/raddr_i -> rdata_o : registered read, updated only when re_i is high
//   we_i/waddr_i/wdata_i/wstrb_i : byte-masked write
// A read and write to the same word on the same edge returns the old word.
// The array itself has no reset; only the read register is cleared.
module sram_1r1w #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slv.sv
// AXI4-Lite responder in front of sram_1r1w, with independent read and write
// FSMs and per-channel access-latency down-counters.
//   clk_i  : the only clock
//   rst_ni : asynchronous active-low reset
//   bus    : AXI4-Lite slave modport (AR, R, AW, W, B channels)
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake
// R_ACC  | counting down rcnt, sample memory when it reaches zero
// R_RESP | rvalid high, holding rdata/rresp until rready
// W_IDLE | accepting AW and W independently until both are held
// W_ACC  | counting down wcnt, commit the write when it reaches zero
// W_RESP | bvalid high, holding bresp until bready
module axi_sram_slv
  import axi_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                R_LAT  = 2,
  parameter int                W_LAT  = 2
) (
  input logic           clk_i,
  input logic           rst_ni,
  axi_sram_slv_if.slave bus
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN    = ADDR_W'(4 * DEPTH);
  localparam logic [7:0]        R_LAT_C = 8'(R_LAT);
  localparam logic [7:0]        W_LAT_C = 8'(W_LAT);

  r_state_t          r_state_q, r_state_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [1:0]        rresp_q, rresp_d;

  w_state_t          w_state_q, w_state_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              aw_held_q, aw_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              w_held_q, w_held_d;
  logic [1:0]        bresp_q, bresp_d;

  logic              mem_re, mem_we;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] r_off, w_off;
  logic              r_in, w_in;
  logic              aw_hs, w_hs;

  // Offsets below BASE wrap to large values, so the lower bound is checked
  // separately.
  assign r_off = raddr_q - BASE;
  assign w_off = awaddr_q - BASE;
  assign r_in  = (raddr_q >= BASE) && (r_off < SPAN);
  assign w_in  = (awaddr_q >= BASE) && (w_off < SPAN);

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_RESP);
  assign bus.rresp   = rresp_q;
  // The SRAM read register is left untouched on an out-of-range access, so
  // the error response masks it to zero.
  assign bus.rdata   = (rresp_q == RESP_OKAY) ? mem_rdata : '0;

  assign bus.awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign bus.wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign bus.bvalid  = (w_state_q == W_RESP);
  assign bus.bresp   = bresp_q;

  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;

  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    raddr_d   = raddr_q;
    rresp_d   = rresp_q;
    mem_re    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          raddr_d   = bus.araddr;
          rcnt_d    = R_LAT_C;
          r_state_d = R_ACC;
        end
      end
      R_ACC: begin
        if (rcnt_q == 8'd0) begin
          mem_re    = r_in;
          rresp_d   = r_in ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      R_RESP: begin
        if (bus.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    awaddr_d  = awaddr_q;
    aw_held_d = aw_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_held_d  = w_held_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          awaddr_d  = bus.awaddr;
          aw_held_d = 1'b1;
        end
        if (w_hs) begin
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
          w_held_d = 1'b1;
        end
        // Uses the next-state flags so a same-cycle AW+W pair leaves at once.
        if (aw_held_d && w_held_d) begin
          wcnt_d    = W_LAT_C;
          w_state_d = W_ACC;
        end
      end
      W_ACC: begin
        if (wcnt_q == 8'd0) begin
          mem_we    = w_in;
          bresp_d   = w_in ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      raddr_q   <= '0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      wcnt_q    <= '0;
      awaddr_q  <= '0;
      aw_held_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_held_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      raddr_q   <= raddr_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      awaddr_q  <= awaddr_d;
      aw_held_q <= aw_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_held_q  <= w_held_d;
      bresp_q   <= bresp_d;
    end
  end

  sram_1r1w #(.DEPTH(DEPTH)) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (mem_re),
    .raddr_i (r_off[IDX_W+1:2]),
    .rdata_o (mem_rdata),
    .we_i    (mem_we),
    .waddr_i (w_off[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q)
  );

endmodule

// File: tb/tb_axi_sram_slv.sv
module tb_axi_sram_slv;
  import axi_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_sram_slv_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  axi_sram_slv_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  axi_sram_slv #(.DEPTH(DEPTH), .BASE(BASE), .R_LAT(2), .W_LAT(2)) u_dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (bus0.slave));
  axi_sram_slv #(.DEPTH(DEPTH), .BASE(BASE), .R_LAT(255), .W_LAT(0)) u_slow (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (bus1.slave));

  // Common driver; sel routes valid/ready to the default (0) or slow (1) instance.
  bit          sel = 1'b0;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  assign bus0.araddr = araddr;   assign bus1.araddr = araddr;
  assign bus0.awaddr = awaddr;   assign bus1.awaddr = awaddr;
  assign bus0.wdata  = wdata;    assign bus1.wdata  = wdata;
  assign bus0.wstrb  = wstrb;    assign bus1.wstrb  = wstrb;
  assign bus0.arvalid = arvalid & ~sel;  assign bus1.arvalid = arvalid & sel;
  assign bus0.rready  = rready  & ~sel;  assign bus1.rready  = rready  & sel;
  assign bus0.awvalid = awvalid & ~sel;  assign bus1.awvalid = awvalid & sel;
  assign bus0.wvalid  = wvalid  & ~sel;  assign bus1.wvalid  = wvalid  & sel;
  assign bus0.bready  = bready  & ~sel;  assign bus1.bready  = bready  & sel;
  assign arready = sel ? bus1.arready : bus0.arready;
  assign rvalid  = sel ? bus1.rvalid  : bus0.rvalid;
  assign rdata   = sel ? bus1.rdata   : bus0.rdata;
  assign rresp   = sel ? bus1.rresp   : bus0.rresp;
  assign awready = sel ? bus1.awready : bus0.awready;
  assign wready  = sel ? bus1.wready  : bus0.wready;
  assign bvalid  = sel ? bus1.bvalid  : bus0.bvalid;
  assign bresp   = sel ? bus1.bresp   : bus0.bresp;

  int errors = 0;
  int checks = 0;

  // Reference memory for the default instance: word value plus which bytes
  // have ever been written (unwritten bytes hold unknown power-up contents).
  logic [31:0] model_mem   [int];
  logic [3:0]  model_known [int];

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned la = a;
    longint unsigned lb = BASE;
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] known_mask(input logic [31:0] a);
    logic [31:0] m = '0;
    int idx = idx_of(a);
    if (model_known.exists(idx))
      for (int b = 0; b < 4; b++) if (model_known[idx][b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int idx = idx_of(a);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (!in_rng(a)) return;
    idx = idx_of(a);
    if (!model_mem.exists(idx)) begin
      model_mem[idx]   = '0;
      model_known[idx] = '0;
    end
    for (int b = 0; b < 4; b++)
      if (s[b]) begin
        model_mem[idx][8*b +: 8] = d[8*b +: 8];
        model_known[idx][b]      = 1'b1;
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end #1 after a rising edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] r, output int lat);
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < 600) begin @(posedge clk_i); #1; n++; end
    @(posedge clk_i); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 600) begin @(posedge clk_i); #1; lat++; end
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk_i); #1;
    rready = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] r, output int lat);
    bit aw_done = 1'b0, w_done = 1'b0, aw_now, w_now;
    int k = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && k < 600) begin
      awvalid = !aw_done && (k >= aw_dly);
      wvalid  = !w_done && (k >= w_dly);
      aw_now  = awvalid && awready;
      w_now   = wvalid && wready;
      @(posedge clk_i); #1;
      k++;
      aw_done = aw_done | aw_now;
      w_done  = w_done | w_now;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (!bvalid && lat < 600) begin @(posedge clk_i); #1; lat++; end
    r = bresp;
    bready = 1'b1;
    @(posedge clk_i); #1;
    bready = 1'b0;
  endtask

  task automatic wr_check(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly, input int w_dly);
    logic [1:0] r;
    int lat;
    bus_write(a, d, s, aw_dly, w_dly, r, lat);
    chk({tag, "_blat"}, lat, 3);
    chk({tag, "_bresp"}, r, in_rng(a) ? RESP_OKAY : RESP_SLVERR);
    model_write(a, d, s);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, output logic [31:0] d);
    logic [1:0] r;
    logic [31:0] m;
    int lat;
    bus_read(a, d, r, lat);
    chk({tag, "_rlat"}, lat, 3);
    if (in_rng(a)) begin
      chk({tag, "_rresp"}, r, RESP_OKAY);
      m = known_mask(a);
      if (m != 0) chk({tag, "_rdata"}, d & m, model_word(a) & m);
    end else begin
      chk({tag, "_rresp"}, r, RESP_SLVERR);
      chk({tag, "_rdata"}, d, 32'h0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"},  wready,  1);
    chk({tag, "_rvalid"},  rvalid,  0);
    chk({tag, "_bvalid"},  bvalid,  0);
    chk({tag, "_rdata"},   rdata,   0);
    chk({tag, "_rresp"},   rresp,   0);
    chk({tag, "_bresp"},   bresp,   0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, hold_d, a;
    logic [1:0]  r;
    int          lat, rl, wl;

    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;

    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single read
    wr_check("pre0", BASE, 32'hDEADBEEF, 4'hF, 0, 0);
    rd_check("rd0", BASE, d);
    chk("rd0_lit", d, 32'hDEADBEEF);

    // Write with W three cycles after AW, partial strobes
    wr_check("pre10", BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wr_check("wr10", BASE + 32'h10, 32'h1234_5678, 4'b0101, 0, 3);
    rd_check("rd10", BASE + 32'h10, d);
    chk("rd10_lit", d, 32'hFF34_FF78);
    // W before AW
    wr_check("wfirst", BASE + 32'h14, 32'h0F0F_0F0F, 4'hF, 2, 0);
    rd_check("wfirst", BASE + 32'h14, d);

    // wstrb = 0 changes nothing
    wr_check("strb0", BASE + 32'h10, 32'h0000_0000, 4'b0000, 0, 0);
    rd_check("strb0", BASE + 32'h10, d);
    chk("strb0_lit", d, 32'hFF34_FF78);

    // Out of range (0x8000_4000 would alias word 0 if decoded loosely)
    rd_check("oor", 32'h8000_4000, d);
    wr_check("oor", 32'h8000_4000, 32'h5555_AAAA, 4'hF, 0, 0);
    rd_check("oor_w0", BASE, d);
    chk("oor_w0_lit", d, 32'hDEADBEEF);
    rd_check("below", BASE - 4, d);
    // Last word, low address bits ignored
    wr_check("last", BASE + 32'h3FFC, 32'h7777_1111, 4'hF, 0, 0);
    rd_check("last", BASE + 32'h3FFF, d);

    // Backpressure on R while a write completes
    araddr = BASE + 32'h10; arvalid = 1'b1;
    @(posedge clk_i); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 600) begin @(posedge clk_i); #1; lat++; end
    chk("bp_rlat", lat, 3);
    hold_d = rdata;
    chk("bp_rdata", hold_d, 32'hFF34_FF78);
    wr_check("bp_wr", BASE + 32'h40, 32'h0000_55AA, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rvalid", rvalid, 1);
      chk("bp_hold", rdata, hold_d);
      chk("bp_arready", arready, 0);
      @(posedge clk_i); #1;
    end
    rready = 1'b1; @(posedge clk_i); #1; rready = 1'b0;
    rd_check("bp_rd40", BASE + 32'h40, d);

    // Collision: sample and commit on the same edge
    wr_check("coll_pre", BASE + 32'h20, 32'hA, 4'hF, 0, 0);
    araddr = BASE + 32'h20; awaddr = BASE + 32'h20; wdata = 32'hB; wstrb = 4'hF;
    arvalid = 1; awvalid = 1; wvalid = 1;
    chk("coll_ready", {29'd0, arready, awready, wready}, 32'd7);
    @(posedge clk_i); #1;
    arvalid = 0; awvalid = 0; wvalid = 0;
    rl = -1; wl = -1; d = '0;
    for (int k = 1; k <= 20 && (rl < 0 || wl < 0); k++) begin
      @(posedge clk_i); #1;
      if (rvalid && rl < 0) begin rl = k; d = rdata; end
      if (bvalid && wl < 0) wl = k;
    end
    chk("coll_rlat", rl, 3);
    chk("coll_wlat", wl, 3);
    chk("coll_old", d, 32'hA);
    rready = 1; bready = 1; @(posedge clk_i); #1; rready = 0; bready = 0;
    model_write(BASE + 32'h20, 32'hB, 4'hF);
    rd_check("coll_new", BASE + 32'h20, d);
    chk("coll_new_lit", d, 32'hB);

    // Reset while in W_ACC
    wr_check("rst_pre", BASE + 32'h30, 32'h0BAD_F00D, 4'hF, 0, 0);
    awaddr = BASE + 32'h30; wdata = 32'hFFFF_0000; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge clk_i); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rd_check("rst_keep", BASE + 32'h30, d);
    chk("rst_keep_lit", d, 32'h0BAD_F00D);
    wr_check("rst_after", BASE + 32'h30, 32'h2468_ACE0, 4'b1100, 1, 0);
    rd_check("rst_after", BASE + 32'h30, d);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: a = BASE - 4;
          1: a = BASE + 4 * DEPTH;
          2: a = 32'h8000_4000;
          3: a = 32'h0000_0010;
          default: a = 32'hFFFF_FFFC;
        endcase
      end else begin
        a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      end
      if ($urandom_range(0, 1) == 1)
        wr_check("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        rd_check("rnd_rd", a, d);
    end

    // Counter extremes on the slow instance: W_LAT=0, R_LAT=255
    sel = 1'b1;
    @(posedge clk_i); #1;
    bus_write(BASE + 32'h8, 32'hC0FF_EE11, 4'hF, 0, 0, r, lat);
    chk("slow_blat", lat, 1);
    chk("slow_bresp", r, RESP_OKAY);
    bus_read(BASE + 32'h8, d, r, lat);
    chk("slow_rlat", lat, 256);
    chk("slow_rresp", r, RESP_OKAY);
    chk("slow_rdata", d, 32'hC0FF_EE11);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
